// File: rtl/irq_ctrl.sv
// Edge/level interrupt controller: latches requests, masks and prioritises them,
// tracks nested in-service channels and supplies the vector during interrupt acknowledge.
module irq_ctrl #(
   parameter int unsigned NUM_IRQ      = 8,
   parameter logic [7:0]  VEC_BASE_RST = 8'h20,
   parameter int unsigned VEC_SHIFT    = 1,
   parameter logic [15:0] IMR_RST      = 16'h0000
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               cs,
   input  logic               we,
   input  logic               stb,
   input  logic [2:0]         addr,
   input  logic [15:0]        din,
   output logic [15:0]        dout,
   output logic               dout_valid,
   output logic               int_rq,
   input  logic               int_ack
);

   localparam int unsigned PW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   typedef enum logic {StIdle, StAck} state_e;

   state_e               state_q, state_d;
   logic [NUM_IRQ-1:0]   imr_q, imr_d, level_q, level_d, irr_q, irr_d, isr_q, isr_d, prev_q;
   logic [7:0]           vbase_q, vbase_d, vec_q, vec_d;
   logic [1:0]           ctrl_q, ctrl_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic                 int_rq_q;

   logic                 srv_found, isr_found, ack_go, wr, eoi_hit;
   logic [PW-1:0]        srv_idx, isr_idx, win, eoi_ch;
   logic [15:0]          rd_data;
   logic                 unused_din;

   assign unused_din = ^din;

   // Channel at priority rank i when the highest-priority channel is p.
   function automatic logic [PW-1:0] rot(input logic [PW-1:0] p, input int unsigned i);
      int unsigned s;
      s = 32'(p) + i;
      if (s >= NUM_IRQ) s = s - NUM_IRQ;
      return PW'(s);
   endfunction

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (32'(p) == NUM_IRQ - 1) ? '0 : p + 1'b1;
   endfunction

   // ISR is checked before IRR at each rank so that an equal-priority pending bit is not serviceable.
   always_comb begin
      srv_found = 1'b0;
      srv_idx   = '0;
      isr_found = 1'b0;
      isr_idx   = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (!isr_found && isr_q[rot(ptr_q, i)]) begin
            isr_found = 1'b1;
            isr_idx   = rot(ptr_q, i);
         end
         if (!isr_found && !srv_found && irr_q[rot(ptr_q, i)] && !imr_q[rot(ptr_q, i)]) begin
            srv_found = 1'b1;
            srv_idx   = rot(ptr_q, i);
         end
      end
   end

   assign ack_go = int_ack & stb & (state_q == StIdle);
   assign wr     = cs & stb & we;
   assign win    = srv_found ? srv_idx : PW'(NUM_IRQ - 1);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (int_ack && stb) state_d = StAck;
         StAck:   if (!(int_ack && stb)) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      imr_d   = imr_q;
      vbase_d = vbase_q;
      ctrl_d  = ctrl_q;
      level_d = level_q;
      irr_d   = irr_q;
      isr_d   = isr_q;
      ptr_d   = ptr_q;
      vec_d   = vec_q;
      eoi_hit = 1'b0;
      eoi_ch  = '0;
      if (wr) begin
         case (addr)
            3'd0: imr_d   = din[NUM_IRQ-1:0];
            3'd1: vbase_d = din[7:0];
            3'd2: ctrl_d  = din[1:0];
            3'd3: level_d = din[NUM_IRQ-1:0];
            3'd4: begin
               if (din[15]) begin
                  for (int unsigned c = 0; c < NUM_IRQ; c++) begin
                     if (din[3:0] == 4'(c) && isr_q[c]) begin
                        eoi_hit = 1'b1;
                        eoi_ch  = PW'(c);
                     end
                  end
               end else begin
                  eoi_hit = isr_found;
                  eoi_ch  = isr_idx;
               end
            end
            default: ;
         endcase
      end
      if (eoi_hit) begin
         isr_d[eoi_ch] = 1'b0;
         if (ctrl_q[1]) ptr_d = nxt(eoi_ch);
      end
      // Ack is applied after EOI so a set on the same ISR bit wins.
      if (ack_go) begin
         vec_d = vbase_q + (8'(win) << VEC_SHIFT);
         if (srv_found) begin
            if (!level_q[win]) irr_d[win] = 1'b0;
            if (ctrl_q[0]) begin
               if (ctrl_q[1]) ptr_d = nxt(win);
            end else begin
               isr_d[win] = 1'b1;
            end
         end
      end
      irr_d = ((irr_d | (irq_in & ~prev_q)) & ~level_q) | (irq_in & level_q);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         imr_q    <= IMR_RST[NUM_IRQ-1:0];
         vbase_q  <= VEC_BASE_RST;
         ctrl_q   <= '0;
         level_q  <= '0;
         irr_q    <= '0;
         isr_q    <= '0;
         prev_q   <= '0;
         ptr_q    <= '0;
         vec_q    <= '0;
         int_rq_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         imr_q    <= imr_d;
         vbase_q  <= vbase_d;
         ctrl_q   <= ctrl_d;
         level_q  <= level_d;
         irr_q    <= irr_d;
         isr_q    <= isr_d;
         prev_q   <= irq_in;
         ptr_q    <= ptr_d;
         vec_q    <= vec_d;
         int_rq_q <= srv_found;
      end
   end

   always_comb begin
      rd_data = '0;
      case (addr)
         3'd0:    rd_data = 16'(imr_q);
         3'd1:    rd_data = {8'h00, vbase_q};
         3'd2:    rd_data = {14'h0000, ctrl_q};
         3'd3:    rd_data = 16'(level_q);
         3'd4:    rd_data = 16'(irr_q);
         3'd5:    rd_data = 16'(isr_q);
         default: rd_data = '0;
      endcase
   end

   assign int_rq     = int_rq_q;
   assign dout       = (state_q == StAck) ? {8'h00, vec_q} : rd_data;
   assign dout_valid = (state_q == StAck) | (cs & stb & ~we & ~int_ack);

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: nesting, masking, AEOI/rotation, spurious ack and reset mid-ack.
module tb_irq_ctrl;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [7:0]  irq_in;
   logic        cs, we, stb, int_ack;
   logic [2:0]  addr;
   logic [15:0] din;
   logic [15:0] dout;
   logic        dout_valid, int_rq;

   int n_checks = 0;
   int n_pass   = 0;

   irq_ctrl dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .irq_in     (irq_in),
      .cs         (cs),
      .we         (we),
      .stb        (stb),
      .addr       (addr),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .int_rq     (int_rq),
      .int_ack    (int_ack)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
      cs = 1'b1; stb = 1'b1; we = 1'b1; addr = a; din = d;
      tick();
      cs = 1'b0; stb = 1'b0; we = 1'b0; din = '0;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
      cs = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
      #1;
      check(tag, dout, exp);
      cs = 1'b0; stb = 1'b0;
      #1;
   endtask

   task automatic pulse(input logic [7:0] m);
      irq_in = m;
      tick();
      irq_in = '0;
   endtask

   task automatic do_ack(input string tag, input logic [15:0] exp_vec, input logic exp_rq);
      int_ack = 1'b1; stb = 1'b1;
      tick();
      check({tag, "_vld"}, 16'(dout_valid), 16'd1);
      check({tag, "_vec"}, dout, exp_vec);
      tick();
      check({tag, "_stable"}, dout, exp_vec);
      check({tag, "_rq"}, 16'(int_rq), 16'(exp_rq));
      int_ack = 1'b0; stb = 1'b0;
      tick();
   endtask

   initial begin
      reset_n = 1'b0; irq_in = '0; cs = 1'b0; we = 1'b0; stb = 1'b0;
      int_ack = 1'b0; addr = '0; din = '0;
      #12;
      check("rst_vld", 16'(dout_valid), 16'd0);
      check("rst_rq", 16'(int_rq), 16'd0);
      reset_n = 1'b1;
      tick();
      rd_chk("rst_imr", 3'd0, 16'h0000);
      rd_chk("rst_vbase", 3'd1, 16'h0020);

      // T1: single edge, two-clock request latency
      pulse(8'h01);
      check("t1_rq_early", 16'(int_rq), 16'd0);
      tick();
      check("t1_rq", 16'(int_rq), 16'd1);
      do_ack("t1_ack", 16'h0020, 1'b0);
      rd_chk("t1_isr", 3'd5, 16'h0001);

      // T2: simultaneous ch0+ch1, non-specific EOI between acks
      wr_reg(3'd4, 16'h0000);
      rd_chk("t2_isr0", 3'd5, 16'h0000);
      pulse(8'h03);
      tick();
      do_ack("t2_ack0", 16'h0020, 1'b0);
      wr_reg(3'd4, 16'h0000);
      tick();
      check("t2_rq1", 16'(int_rq), 16'd1);
      do_ack("t2_ack1", 16'h0022, 1'b0);
      rd_chk("t2_isr", 3'd5, 16'h0002);

      // T3: lower priority blocked, higher priority nests
      pulse(8'h04);
      tick();
      check("t3_rq_blk", 16'(int_rq), 16'd0);
      pulse(8'h01);
      tick();
      check("t3_rq", 16'(int_rq), 16'd1);
      do_ack("t3_ack", 16'h0020, 1'b0);
      rd_chk("t3_isr", 3'd5, 16'h0003);
      wr_reg(3'd4, 16'h800A);
      rd_chk("t3_eoi_oob", 3'd5, 16'h0003);
      wr_reg(3'd4, 16'h0000);
      rd_chk("t3_eoi_ns", 3'd5, 16'h0002);
      wr_reg(3'd4, 16'h0000);
      do_ack("t3_ack2", 16'h0024, 1'b0);
      wr_reg(3'd4, 16'h8002);
      rd_chk("t3_isr_clr", 3'd5, 16'h0000);

      // T4: masked request latches but does not interrupt
      wr_reg(3'd0, 16'h0002);
      pulse(8'h02);
      tick();
      check("t4_rq_mask", 16'(int_rq), 16'd0);
      rd_chk("t4_irr", 3'd4, 16'h0002);
      wr_reg(3'd0, 16'h0000);
      check("t4_rq_wr_edge", 16'(int_rq), 16'd0);
      tick();
      check("t4_rq", 16'(int_rq), 16'd1);
      do_ack("t4_ack", 16'h0022, 1'b0);
      wr_reg(3'd4, 16'h8001);
      rd_chk("t4_isr", 3'd5, 16'h0000);

      // T5: AEOI + rotate
      wr_reg(3'd2, 16'h0003);
      rd_chk("t5_ctrl", 3'd2, 16'h0003);
      pulse(8'h01);
      do_ack("t5_ack0", 16'h0020, 1'b0);
      rd_chk("t5_isr", 3'd5, 16'h0000);
      pulse(8'h03);
      do_ack("t5_ack1", 16'h0022, 1'b1);
      do_ack("t5_ack2", 16'h0020, 1'b0);
      wr_reg(3'd2, 16'h0000);

      // T6: spurious ack, then reset in the middle of an ack
      rd_chk("t6_irr_pre", 3'd4, 16'h0000);
      do_ack("t6_spur", 16'h002E, 1'b0);
      rd_chk("t6_irr", 3'd4, 16'h0000);
      rd_chk("t6_isr", 3'd5, 16'h0000);
      int_ack = 1'b1; stb = 1'b1;
      tick();
      check("t6_vld_ack", 16'(dout_valid), 16'd1);
      reset_n = 1'b0;
      #1;
      check("t6_vld_rst", 16'(dout_valid), 16'd0);
      int_ack = 1'b0; stb = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      check("t6_rq_rst", 16'(int_rq), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
